// File: rtl/kyber_pkg.sv
// Shared Kyber constants and lane/nibble index helpers for the compress and add paths.
package kyber_pkg;

    localparam int unsigned KYBER_Q         = 3329;
    localparam int unsigned KYBER_Q_HALF    = 1665;
    localparam int unsigned COMPRESS4_MULT  = 80635;
    localparam int unsigned COMPRESS4_SHIFT = 28;

    // LSB of coefficient lane k inside a packed beat of w-bit lanes
    function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

    // MSB of nibble k in reversed order: lane 0 occupies the top d bits
    function automatic int unsigned nibble_msb(input int unsigned k, input int unsigned n,
                                               input int unsigned d);
        return n * d - 1 - k * d;
    endfunction

endpackage

// File: rtl/compress4_lane.sv
// Combinational Compress_q(u,4) for one normalised coefficient, reference-exact uint32 arithmetic.
module compress4_lane
    import kyber_pkg::*;
(
    input  logic [15:0] u_i,
    output logic [3:0]  c_o
);

    logic [31:0] t;
    logic [31:0] prod;

    // Product wraps mod 2^32 exactly like the C reference; this yields 0 for u near Q.
    always_comb begin
        t    = {16'd0, u_i} << 4;
        t    = t + KYBER_Q_HALF;
        prod = t * COMPRESS4_MULT;
        c_o  = prod[COMPRESS4_SHIFT +: 4];
    end

endmodule

// File: rtl/poly_compress4_packer.sv
// Streaming Compress_q(x,4) of eight signed coefficients per beat into 32-bit packed nibbles.
module poly_compress4_packer
    import kyber_pkg::*;
#(
    parameter int unsigned N_LANES        = 8,
    parameter int unsigned COEFF_W        = 16,
    parameter int unsigned D              = 4,
    parameter int unsigned BEATS_PER_POLY = 32
) (
    input  logic                         iClk,
    input  logic                         iRst,
    input  logic                         iClear,
    input  logic                         iValid,
    output logic                         oReady,
    input  logic [N_LANES*COEFF_W-1:0]   iCoeffs,
    output logic                         oValid,
    input  logic                         iReady,
    output logic [N_LANES*D-1:0]         oPacked,
    output logic                         oLast,
    output logic                         oRangeErr
);

    localparam int unsigned CNT_W = $clog2(BEATS_PER_POLY);
    localparam logic signed [COEFF_W-1:0] Q_S = COEFF_W'(KYBER_Q);

    logic                              s1_valid_q, s1_valid_d;
    logic [N_LANES-1:0][COEFF_W-1:0]   s1_u_q, s1_u_d;
    logic                              s1_err_q, s1_err_d;
    logic                              s2_valid_q, s2_valid_d;
    logic [N_LANES*D-1:0]              packed_q, packed_d;
    logic                              err_q, err_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;

    logic                              advance;
    logic [N_LANES-1:0][COEFF_W-1:0]   u_in;
    logic [N_LANES-1:0]                lane_oor;
    logic [N_LANES-1:0][D-1:0]         lane_c;
    logic [N_LANES*D-1:0]              packed_c;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        logic signed [COEFF_W-1:0] x;
        assign x           = iCoeffs[lane_lsb(k, COEFF_W) +: COEFF_W];
        assign lane_oor[k] = (x >= Q_S) || (x <= -Q_S);
        assign u_in[k]     = x[COEFF_W-1] ? COEFF_W'(x + Q_S) : x;

        compress4_lane u_lane (
            .u_i (s1_u_q[k]),
            .c_o (lane_c[k])
        );
    end

    always_comb begin
        packed_c = '0;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            packed_c[nibble_msb(k, N_LANES, D) -: D] = lane_c[k];
        end
    end

    assign advance   = ~s2_valid_q | iReady;
    assign oReady    = advance;
    assign oValid    = s2_valid_q;
    assign oPacked   = packed_q;
    assign oRangeErr = err_q;
    assign oLast     = s2_valid_q & (cnt_q == CNT_W'(BEATS_PER_POLY - 1));

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_u_d     = s1_u_q;
        s1_err_d   = s1_err_q;
        s2_valid_d = s2_valid_q;
        packed_d   = packed_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        if (advance) begin
            s1_valid_d = iValid;
            s1_u_d     = u_in;
            s1_err_d   = |lane_oor;
            s2_valid_d = s1_valid_q;
            packed_d   = packed_c;
            if (s1_valid_q && s1_err_q) err_d = 1'b1;
        end

        if (s2_valid_q && iReady) begin
            cnt_d = (cnt_q == CNT_W'(BEATS_PER_POLY - 1)) ? '0 : cnt_q + 1'b1;
        end

        // Clear wins over any same-cycle handshake or error capture
        if (iClear) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            cnt_d      = '0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s1_valid_q <= 1'b0;
            s1_u_q     <= '0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            packed_q   <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_u_q     <= s1_u_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            packed_q   <= packed_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_poly_compress4_packer.sv
// Scoreboard bench for poly_compress4_packer: directed steps, golden round(16u/Q) mod 16 model.
module tb_poly_compress4_packer;

    logic         iClk = 1'b0;
    logic         iRst, iClear, iValid, iReady;
    logic [127:0] iCoeffs;
    logic         oReady, oValid, oLast, oRangeErr;
    logic [31:0]  oPacked;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    int          mcnt = 0;
    int          last_cnt = 0;
    bit          stall_v = 1'b0;
    logic [31:0] stall_w;

    poly_compress4_packer #(
        .N_LANES        (8),
        .COEFF_W        (16),
        .D              (4),
        .BEATS_PER_POLY (32)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iClear    (iClear),
        .iValid    (iValid),
        .oReady    (oReady),
        .iCoeffs   (iCoeffs),
        .oValid    (oValid),
        .iReady    (iReady),
        .oPacked   (oPacked),
        .oLast     (oLast),
        .oRangeErr (oRangeErr)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_c(input int x);
        int u;
        u = (x < 0) ? x + 3329 : x;
        return 4'(((32 * u + 3329) / 6658) % 16);
    endfunction

    function automatic logic [31:0] model_word(input logic [127:0] c);
        logic [31:0] w;
        logic [15:0] f;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            f = c[16*k +: 16];
            w[31-4*k -: 4] = ref_c(int'($signed(f)));
        end
        return w;
    endfunction

    function automatic logic [127:0] mk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        int a[8];
        logic [127:0] r;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        for (int k = 0; k < 8; k++) r[16*k +: 16] = 16'(a[k]);
        return r;
    endfunction

    function automatic logic [127:0] rnd_beat();
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = 16'(int'($urandom_range(0, 6656)) - 3328);
        return r;
    endfunction

    // Monitor: sees inputs stable before the coming posedge, so handshakes are known here
    always @(negedge iClk) begin
        if (iRst || iClear) begin
            sb.delete();
            mcnt    = 0;
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                chk("stall_valid", {31'd0, oValid}, 32'd1);
                chk("stall_hold", oPacked, stall_w);
            end
            if (oValid) begin
                chk("last", {31'd0, oLast}, {31'd0, mcnt == 31});
                if (oLast) last_cnt++;
            end
            if (oValid && iReady) begin
                chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) chk("packed", oPacked, sb.pop_front());
                mcnt = (mcnt + 1) % 32;
            end
            stall_v = oValid && !iReady;
            stall_w = oPacked;
            if (iValid && oReady) sb.push_back(model_word(iCoeffs));
        end
    end

    task automatic send(input logic [127:0] c, input bit rnd);
        bit acc;
        acc     = 1'b0;
        iCoeffs = c;
        iValid  = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            iReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge iClk);
            acc = oReady;
            @(posedge iClk);
            #1;
        end
        chk("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain();
        bit done;
        iValid = 1'b0;
        iReady = 1'b1;
        done   = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (sb.size() == 0 && !oValid) done = 1'b1;
            else begin
                @(posedge iClk);
                #1;
            end
        end
        chk("drain", {31'd0, done}, 32'd1);
    endtask

    task automatic clear_pulse();
        iClear = 1'b1;
        @(posedge iClk);
        #1;
        iClear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iRst = 1'b1; iClear = 1'b0; iValid = 1'b0; iReady = 1'b0; iCoeffs = '0;
        #2;
        chk("rst_valid", {31'd0, oValid}, 32'd0);
        chk("rst_packed", oPacked, 32'd0);
        chk("rst_last", {31'd0, oLast}, 32'd0);
        chk("rst_err", {31'd0, oRangeErr}, 32'd0);
        chk("rst_ready", {31'd0, oReady}, 32'd1);
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
        @(posedge iClk);
        #1;

        // Single beat latency and known packing
        send(mk8(0, 832, 1665, 3328, -1, -1665, 208, 416), 1'b0);
        iValid = 1'b0;
        chk("t1_lat_s1", {31'd0, oValid}, 32'd0);
        @(posedge iClk); #1;
        chk("t1_valid", {31'd0, oValid}, 32'd1);
        chk("t1_packed", oPacked, 32'h0480_0812);
        @(posedge iClk); #1;
        chk("t1_valid_drop", {31'd0, oValid}, 32'd0);

        // Edge nibbles: 1664 -> 8, 3328 -> 0
        send(mk8(1664, 3328, -1665, -1, 0, 0, 0, 0), 1'b0);
        iValid = 1'b0;
        @(posedge iClk); #1;
        chk("edge_packed", oPacked, 32'h8080_0000);
        drain();

        // Full u sweep 0..3328, alternating positive and negative encodings
        for (int b = 0; b < 417; b++) begin
            logic [127:0] c;
            for (int k = 0; k < 8; k++) begin
                int u, x;
                u = b * 8 + k;
                if (u > 3328) u = 3328;
                x = ((b % 2) == 1 && u != 0) ? u - 3329 : u;
                c[16*k +: 16] = 16'(x);
            end
            send(c, 1'b0);
        end
        drain();

        // 33 back-to-back beats: oLast only on the 32nd, counter wraps
        clear_pulse();
        last_cnt = 0;
        for (int b = 0; b < 33; b++) send(rnd_beat(), 1'b0);
        drain();
        chk("t2_last_count", 32'(last_cnt), 32'd1);

        // Random backpressure
        clear_pulse();
        for (int b = 0; b < 8; b++) send(rnd_beat(), 1'b1);
        drain();

        // Range error sticky and cleared by iClear
        clear_pulse();
        send(mk8(3329, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        iValid = 1'b0;
        chk("t5_err_early", {31'd0, oRangeErr}, 32'd0);
        @(posedge iClk); #1;
        chk("t5_err_set", {31'd0, oRangeErr}, 32'd1);
        repeat (3) @(posedge iClk);
        #1;
        chk("t5_err_sticky", {31'd0, oRangeErr}, 32'd1);
        clear_pulse();
        chk("t5_err_clear", {31'd0, oRangeErr}, 32'd0);
        send(mk8(0, 0, 0, 0, 0, 0, 0, -3329), 1'b0);
        iValid = 1'b0;
        @(posedge iClk); #1;
        chk("t5_err_neg", {31'd0, oRangeErr}, 32'd1);
        drain();
        clear_pulse();

        // Reset with a full pipeline mid-polynomial
        for (int b = 0; b < 17; b++) begin
            if (b == 3) send(mk8(0, 3329, 0, 0, 0, 0, 0, 0), 1'b0);
            else        send(rnd_beat(), 1'b0);
        end
        chk("t6_err_before", {31'd0, oRangeErr}, 32'd1);
        iRst = 1'b1;
        #1;
        chk("t6_valid", {31'd0, oValid}, 32'd0);
        chk("t6_last", {31'd0, oLast}, 32'd0);
        chk("t6_err", {31'd0, oRangeErr}, 32'd0);
        iValid = 1'b0;
        @(posedge iClk); #1;
        iRst = 1'b0;
        @(posedge iClk); #1;
        last_cnt = 0;
        for (int b = 0; b < 32; b++) send(rnd_beat(), 1'b0);
        drain();
        chk("t6_last_count", 32'(last_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
